// File: rtl/ncl_pkg.sv
// Shared dual-rail NCL definitions: rail codes as {t,f}, receiver states, defaults.
// Used by the clocked receiver and by the NCL-side transmitter.
package ncl_pkg;

  localparam logic [1:0] NCL_NULL    = 2'b00;
  localparam logic [1:0] NCL_DATA0   = 2'b01;
  localparam logic [1:0] NCL_DATA1   = 2'b10;
  localparam logic [1:0] NCL_ILLEGAL = 2'b11;

  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    WAIT_DATA = 2'd0,
    HOLD      = 2'd1,
    WAIT_NULL = 2'd2
  } rx_state_t;

endpackage

// File: rtl/ncl_completion_detect.sv
// Combinational completion detection over a dual-rail bus: complete/empty/illegal plus decoded word.
// Zero latency; no flow control of its own.
module ncl_completion_detect
  import ncl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_t,
  input  logic [WIDTH-1:0] in_f,
  output logic             complete,
  output logic             empty,
  output logic             illegal,
  output logic [WIDTH-1:0] word
);

  always_comb begin
    complete = 1'b1;
    empty    = 1'b1;
    illegal  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      case ({in_t[i], in_f[i]})
        NCL_NULL:             complete = 1'b0;
        NCL_DATA0, NCL_DATA1: empty    = 1'b0;
        default: begin
          complete = 1'b0;
          empty    = 1'b0;
          illegal  = 1'b1;
        end
      endcase
    end
  end

  // DATA1 means the true rail is high, so the true rails are the binary word.
  assign word = in_t;

endmodule

// File: rtl/ncl_dr_receiver.sv
// Dual-rail NCL receiver: sync, capture stable DATA wavefront to valid/ready, return ko; SYNC_STAGES+2 cycles to out_valid.
// Holds the word and keeps ko=1 while out_ready is low; sender is stalled by ko until the word is taken.
module ncl_dr_receiver
  import ncl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_t,
  input  logic [WIDTH-1:0] in_f,
  output logic             ko,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_illegal,
  output logic             err_timeout
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  logic [WIDTH-1:0] sync_t [SYNC_STAGES];
  logic [WIDTH-1:0] sync_f [SYNC_STAGES];
  logic [WIDTH-1:0] st, sf, word, prev_word;
  logic             complete, empty, illegal;
  logic             prev_complete, prev_empty;
  logic             stable, capture, accept, timer_run, timer_inc;
  logic [TW-1:0]    timer;
  rx_state_t        state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_t[i] <= '0;
        sync_f[i] <= '0;
      end
    end else begin
      sync_t[0] <= in_t;
      sync_f[0] <= in_f;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_t[i] <= sync_t[i-1];
        sync_f[i] <= sync_f[i-1];
      end
    end
  end

  assign st = sync_t[SYNC_STAGES-1];
  assign sf = sync_f[SYNC_STAGES-1];

  ncl_completion_detect #(.WIDTH(WIDTH)) u_cd (
    .in_t     (st),
    .in_f     (sf),
    .complete (complete),
    .empty    (empty),
    .illegal  (illegal),
    .word     (word)
  );

  // Two identical complete samples in a row filter inter-rail skew at the sync boundary.
  assign stable = complete && prev_complete && (word == prev_word);

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    accept    = 1'b0;
    timer_run = 1'b0;
    case (state)
      WAIT_DATA: begin
        timer_run = !empty || (timer != '0);
        if (stable) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          accept    = 1'b1;
          state_nxt = WAIT_NULL;
        end
      end
      WAIT_NULL: begin
        timer_run = 1'b1;
        if (empty && prev_empty) state_nxt = WAIT_DATA;
      end
      default: state_nxt = WAIT_DATA;
    endcase
  end

  assign timer_inc = timer_run && (state_nxt == state) && (timer != TMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_DATA;
      ko            <= 1'b1;
      out_valid     <= 1'b0;
      out_data      <= '0;
      err_illegal   <= 1'b0;
      err_timeout   <= 1'b0;
      prev_complete <= 1'b0;
      prev_empty    <= 1'b0;
      prev_word     <= '0;
      timer         <= '0;
    end else begin
      state         <= state_nxt;
      ko            <= (state_nxt != WAIT_NULL);
      prev_complete <= complete;
      prev_empty    <= empty;
      prev_word     <= word;
      if (capture) begin
        out_data  <= word;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (illegal && state != HOLD) err_illegal <= 1'b1;
      if (state_nxt != state) begin
        timer <= '0;
      end else if (timer_inc) begin
        timer <= timer + 1'b1;
        if (TIMEOUT > 0 && (timer + 1'b1) == TMAX) err_timeout <= 1'b1;
      end
    end
  end

endmodule
